// File: rtl/cache_line_controller.sv
// Direct-mapped write-back cache line controller: tag clear after reset, hit service,
// dirty-line write-back, 4-word line fill and replay of the held CPU request.
// Optional hit/miss counters are enabled by defining CACHE_LINE_CONTROLLER_STATS_EN.
module cache_line_controller #(
  parameter int unsigned LINE_IX_BITWIDTH = 10,
  parameter int unsigned ADDRESS_BITWIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDRESS_BITWIDTH-1:0] address,
  input  logic [31:0]                 data_in,
  input  logic [3:0]                  write_enable,
  input  logic                        read_enable,
  output logic [31:0]                 data_out,
  output logic                        data_out_ready,
  output logic                        busy,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDRESS_BITWIDTH-1:0] mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic [31:0]                 mem_rdata,
  input  logic                        mem_ack,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);

  localparam int unsigned TagW  = ADDRESS_BITWIDTH - LINE_IX_BITWIDTH - 4;
  localparam int unsigned Lines = 2 ** LINE_IX_BITWIDTH;

  typedef struct packed {
    logic            valid;
    logic            dirty;
    logic [TagW-1:0] tag;
  } tag_entry_t;

  typedef enum logic [2:0] {StClear, StIdle, StWb, StFill, StUpdate, StReplay} state_e;

  state_e state_q, state_d;

  tag_entry_t  tag_ram  [Lines];
  logic [31:0] word_ram [4][Lines];

  logic [LINE_IX_BITWIDTH-1:0] clr_ix_q;
  logic [1:0]                  word_q;
  logic                        mem_req_q;

  // Request decode; the CPU holds these stable while busy, so no request latch is needed.
  logic [TagW-1:0]             req_tag;
  logic [LINE_IX_BITWIDTH-1:0] req_ix;
  logic [1:0]                  req_word;
  logic                        unused_addr;
  tag_entry_t                  cur_entry;
  logic                        hit, is_write, is_req, do_access, word_ack;

  assign req_tag     = address[ADDRESS_BITWIDTH-1:LINE_IX_BITWIDTH+4];
  assign req_ix      = address[LINE_IX_BITWIDTH+3:4];
  assign req_word    = address[3:2];
  assign unused_addr = ^address[1:0];
  assign cur_entry   = tag_ram[req_ix];
  assign hit         = cur_entry.valid && (cur_entry.tag == req_tag);
  assign is_write    = |write_enable;
  assign is_req      = is_write || read_enable;
  assign word_ack    = mem_req_q && mem_ack;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StClear;
    else        state_q <= state_d;
  end

  // Next state, busy and request-execution strobe.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    do_access = 1'b0;
    unique case (state_q)
      StClear: if (&clr_ix_q) state_d = StIdle;
      StIdle: begin
        busy = 1'b0;
        if (is_req) begin
          if (hit) begin
            do_access = 1'b1;
          end else begin
            busy    = 1'b1;
            state_d = (cur_entry.valid && cur_entry.dirty) ? StWb : StFill;
          end
        end
      end
      StWb:     if (word_ack && word_q == 2'd3) state_d = StFill;
      StFill:   if (word_ack && word_q == 2'd3) state_d = StUpdate;
      StUpdate: state_d = StReplay;
      StReplay: begin
        busy      = 1'b0;
        do_access = is_req;
        state_d   = StIdle;
      end
      default:  state_d = StClear;
    endcase
  end

  // RAM write controls: tag clear, tag install, write-hit merge and fill data.
  logic                        tag_we, word_we;
  logic [LINE_IX_BITWIDTH-1:0] tag_wix;
  tag_entry_t                  tag_wdata;
  logic [1:0]                  word_wsel;
  logic [3:0]                  word_be;
  logic [31:0]                 word_wdata;

  always_comb begin
    tag_we     = 1'b0;
    tag_wix    = req_ix;
    tag_wdata  = '0;
    word_we    = 1'b0;
    word_wsel  = req_word;
    word_be    = write_enable;
    word_wdata = data_in;
    if (state_q == StClear) begin
      tag_we  = 1'b1;
      tag_wix = clr_ix_q;
    end else if (state_q == StUpdate) begin
      tag_we    = 1'b1;
      tag_wdata = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
    end else if (do_access && is_write) begin
      tag_we    = 1'b1;
      tag_wdata = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
      word_we   = 1'b1;
    end
    if (state_q == StFill && word_ack) begin
      word_we    = 1'b1;
      word_wsel  = word_q;
      word_be    = 4'hf;
      word_wdata = mem_rdata;
    end
  end

  // Tag and word RAMs; word RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (tag_we) tag_ram[tag_wix] <= tag_wdata;
    if (word_we) begin
      for (int b = 0; b < 4; b++) begin
        if (word_be[b]) word_ram[word_wsel][req_ix][8*b +: 8] <= word_wdata[8*b +: 8];
      end
    end
  end

  // Clear index walks every line once after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  clr_ix_q <= '0;
    else if (state_q == StClear) clr_ix_q <= clr_ix_q + LINE_IX_BITWIDTH'(1);
  end

  // Memory word handshake; the request drops for one cycle after every ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      word_q    <= 2'd0;
    end else if (state_q == StWb || state_q == StFill) begin
      if (!mem_req_q) begin
        mem_req_q <= 1'b1;
        mem_we    <= (state_q == StWb);
        mem_addr  <= (state_q == StWb) ? {cur_entry.tag, req_ix, word_q, 2'b00}
                                       : {req_tag, req_ix, word_q, 2'b00};
        mem_wdata <= word_ram[word_q][req_ix];
      end else if (mem_ack) begin
        mem_req_q <= 1'b0;
        word_q    <= word_q + 2'd1;
      end
    end
  end

  assign mem_req = mem_req_q;

  // Read data register; ready pulses only for reads executed in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out       <= '0;
      data_out_ready <= 1'b0;
    end else begin
      data_out_ready <= 1'b0;
      if (do_access && !is_write) begin
        data_out       <= word_ram[req_word][req_ix];
        data_out_ready <= 1'b1;
      end
    end
  end

`ifdef CACHE_LINE_CONTROLLER_STATS_EN
  logic count_hit, count_miss;
  logic [31:0] hit_count_q, miss_count_q;

  assign count_hit  = (state_q == StIdle) && is_req && hit;
  assign count_miss = (state_q == StIdle) && is_req && !hit;

  // Free-running wrap-around hit/miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (count_hit)  hit_count_q  <= hit_count_q + 32'd1;
      if (count_miss) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_line_controller.sv
// Directed bench for cache_line_controller with a 2-cycle-ack word memory model.
module tb_cache_line_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] address, data_in, data_out, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;
  logic [3:0]  write_enable;
  logic        read_enable, data_out_ready, busy, mem_req, mem_we, mem_ack;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  int wait_cycles;

  logic [31:0] model [logic [31:0]];
  logic        log_we [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_wdata [$];

  cache_line_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .data_in        (data_in),
    .write_enable   (write_enable),
    .read_enable    (read_enable),
    .data_out       (data_out),
    .data_out_ready (data_out_ready),
    .busy           (busy),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req) req_cycles <= req_cycles + 1;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model.exists(a)) return model[a];
    return 32'h5a5a_0000 | {16'h0, a[15:0]};
  endfunction

  // Memory side: ack two cycles after mem_req is seen, one-cycle pulse.
  initial begin : mem_model
    int ack_cnt;
    ack_cnt   = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req && rst_n) begin
        ack_cnt++;
        if (ack_cnt == 2) begin
          ack_cnt = 0;
          mem_ack = 1'b1;
          log_we.push_back(mem_we);
          log_addr.push_back(mem_addr);
          log_wdata.push_back(mem_wdata);
          if (mem_we) model[mem_addr] = mem_wdata;
          else        mem_rdata = model_rd(mem_addr);
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag, input int h, input int m);
`ifdef CACHE_LINE_CONTROLLER_STATS_EN
    check({tag, "_hits"}, hit_count, h);
    check({tag, "_misses"}, miss_count, m);
`else
    check({tag, "_hits"}, hit_count, 0);
    check({tag, "_misses"}, miss_count, 0);
    if (h < 0 || m < 0) $display("negative tally");
`endif
  endtask

  // Present a request, hold it while busy, return at the negedge after acceptance.
  task automatic access(input logic [3:0] we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata);
    address      = addr;
    data_in      = wdata;
    write_enable = we;
    read_enable  = re;
    #1;
    wait_cycles = 0;
    while (busy && wait_cycles < 3000) begin
      @(negedge clk);
      #1;
      wait_cycles++;
    end
    if (busy) check("access_timeout", {31'h0, busy}, 32'h0);
    @(negedge clk);
    write_enable = 4'h0;
    read_enable  = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, 1024);
  endtask

  task automatic check_log(input string tag, input int i, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (i >= log_addr.size()) begin
      check({tag, "_missing"}, log_addr.size(), i + 1);
    end else begin
      check({tag, "_we"}, {31'h0, log_we[i]}, {31'h0, we});
      check({tag, "_addr"}, log_addr[i], addr);
      if (we) check({tag, "_wdata"}, log_wdata[i], wdata);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int base, n;
    logic [31:0] exp_wb [4];
    address      = '0;
    data_in      = '0;
    write_enable = 4'h0;
    read_enable  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model[32'h40 + 4 * i]   = 32'h1111_0000 + i;
      model[32'h4040 + 4 * i] = 32'h2222_0000 + i;
      model[32'h80 + 4 * i]   = 32'h3333_0000 + i;
    end
    model[32'h88] = 32'h1234_5678;

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h1);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_ready", {31'h0, data_out_ready}, 32'h0);
    check_counts("rst", 0, 0);
    rst_n = 1'b1;
    wait_clear("clear_cycles");
    check("clear_no_mem_req", req_cycles, 0);

    // Cold read miss at 0x40: fill 4 words, replay returns word 0.
    base = log_addr.size();
    access(4'h0, 1'b1, 32'h40, '0);
    check("cold_ready", {31'h0, data_out_ready}, 32'h1);
    check("cold_data", data_out, 32'h1111_0000);
    check("cold_txns", log_addr.size() - base, 4);
    for (int i = 0; i < 4; i++) check_log("cold_fill", base + i, 1'b0, 32'h40 + 4 * i, '0);

    // Immediate re-read hit, 1-cycle latency, no memory traffic.
    base = log_addr.size();
    access(4'h0, 1'b1, 32'h44, '0);
    check("hit_wait", wait_cycles, 0);
    check("hit_ready", {31'h0, data_out_ready}, 32'h1);
    check("hit_data", data_out, 32'h1111_0001);
    @(negedge clk);
    check("idle_ready", {31'h0, data_out_ready}, 32'h0);

    // Write hits with full and partial strobes, then read back merged word.
    access(4'hf, 1'b0, 32'h44, 32'habcd_ef12);
    check("wr_ready", {31'h0, data_out_ready}, 32'h0);
    access(4'h1, 1'b0, 32'h44, 32'h0000_00ab);
    access(4'h0, 1'b1, 32'h44, '0);
    check("merge_data", data_out, 32'habcd_efab);
    check("hit_no_txns", log_addr.size() - base, 0);

    // Conflict miss on dirty line: write-back then fill.
    base = log_addr.size();
    access(4'h0, 1'b1, 32'h4044, '0);
    check("evict_data", data_out, 32'h2222_0001);
    check("evict_txns", log_addr.size() - base, 8);
    exp_wb[0] = 32'h1111_0000;
    exp_wb[1] = 32'habcd_efab;
    exp_wb[2] = 32'h1111_0002;
    exp_wb[3] = 32'h1111_0003;
    for (int i = 0; i < 4; i++) check_log("wb", base + i, 1'b1, 32'h40 + 4 * i, exp_wb[i]);
    for (int i = 0; i < 4; i++) check_log("fill", base + 4 + i, 1'b0, 32'h4040 + 4 * i, '0);

    // Write miss with upper-half strobes.
    access(4'hc, 1'b0, 32'h88, 32'hfeef_0000);
    check("wmiss_ready", {31'h0, data_out_ready}, 32'h0);
    access(4'h0, 1'b1, 32'h88, '0);
    check("wmiss_wait", wait_cycles, 0);
    check("wmiss_data", data_out, 32'hfeef_5678);
    check_counts("mid", 5, 3);

    // Evicting that line must write it back first.
    base = log_addr.size();
    access(4'h0, 1'b1, 32'h4088, '0);
    check("evict2_data", data_out, 32'h5a5a_4088);
    check("evict2_txns", log_addr.size() - base, 8);
    check_log("wb2", base + 2, 1'b1, 32'h88, 32'hfeef_5678);
    check_log("fill2", base + 4, 1'b0, 32'h4080, '0);
    check_counts("pre_abort", 5, 4);

    // Abort a fill with reset during its second word.
    base         = log_addr.size();
    address      = 32'hc0;
    read_enable  = 1'b1;
    write_enable = 4'h0;
    n = 0;
    while (log_addr.size() == base && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_log("abort_w0", base, 1'b0, 32'hc0, '0);
    n = 0;
    while (!mem_req && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_req_up", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_req_drop", {31'h0, mem_req}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h1);
    read_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_data_out", data_out, 32'h0);
    check_counts("abort", 0, 0);
    check("abort_txns", log_addr.size() - base, 1);
    rst_n = 1'b1;
    n = req_cycles;
    wait_clear("clear2_cycles");
    check("clear2_no_mem_req", req_cycles - n, 0);

    // Line state lost: 0x44 misses again and refills without write-back.
    base = log_addr.size();
    access(4'h0, 1'b1, 32'h44, '0);
    check("refill_busy_seen", {31'h0, wait_cycles > 0}, 32'h1);
    check("refill_data", data_out, 32'habcd_efab);
    check("refill_txns", log_addr.size() - base, 4);
    check_log("refill", base, 1'b0, 32'h40, '0);
    access(4'h0, 1'b1, 32'h44, '0);
    check("rehit_data", data_out, 32'habcd_efab);
    check_counts("final", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
